// File: rtl/ctr_pkg.sv
// Shared types and helpers for the ctr_bank counter slice.
package ctr_pkg;

    localparam int CTR_SATURATE = 0;
    localparam int CTR_WRAP     = 1;

    typedef struct packed {
        logic en;
        logic up_dn;
        logic load;
    } ctr_ctrl_t;

    function automatic int unsigned ch_lsb(input int unsigned ch,
                                           input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/ctr_channel.sv
// One up/down counter with programmable limit and terminal-count pulse.
module ctr_channel
    import ctr_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int WRAP_MODE = CTR_SATURATE
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             i_user_reset,
    input  ctr_ctrl_t        i_ctrl,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic [WIDTH-1:0] i_limit,
`ifdef CTR_SNAPSHOT_EN
    output logic [WIDTH-1:0] o_nxt,
`endif
    output logic [WIDTH-1:0] o_count,
    output logic             o_at_bound,
    output logic             o_tc
);

    localparam bit LP_WRAP = (WRAP_MODE == CTR_WRAP);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic [WIDTH-1:0] w_nxt;
    logic             w_tc;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic             w_at_max;
    logic             w_at_zero;

    assign w_inc     = r_count + WIDTH'(1);
    assign w_dec     = r_count - WIDTH'(1);
    assign w_at_max  = (r_count >= i_limit);
    assign w_at_zero = (r_count == '0);

    always_comb begin
        w_nxt = r_count;
        w_tc  = 1'b0;
        if (i_user_reset) begin
            w_nxt = '0;
        end else if (i_ctrl.load) begin
            w_nxt = (i_load_val > i_limit) ? i_limit : i_load_val;
        end else if (i_ctrl.en && i_ctrl.up_dn) begin
            if (!w_at_max) begin
                w_nxt = w_inc;
                w_tc  = !LP_WRAP && (w_inc == i_limit);
            end else if (LP_WRAP) begin
                w_nxt = '0;
                w_tc  = 1'b1;
            end else begin
                // limit may have dropped below the count
                w_nxt = i_limit;
            end
        end else if (i_ctrl.en) begin
            if (!w_at_zero) begin
                w_nxt = w_dec;
                w_tc  = !LP_WRAP && (w_dec == '0);
            end else if (LP_WRAP) begin
                w_nxt = i_limit;
                w_tc  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_nxt;
            r_tc    <= w_tc;
        end
    end

    assign o_count    = r_count;
    assign o_tc       = r_tc;
    assign o_at_bound = i_ctrl.up_dn ? (r_count == i_limit) : w_at_zero;
`ifdef CTR_SNAPSHOT_EN
    assign o_nxt      = w_nxt;
`endif

endmodule

// File: rtl/ctr_bank.sv
// Bank of independent up/down counters; CTR_SNAPSHOT_EN adds an
// atomic snapshot register over all channels.
module ctr_bank
    import ctr_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_CH    = 4,
    parameter int WRAP_MODE = CTR_SATURATE
) (
`ifdef CTR_SNAPSHOT_EN
    input  logic                    snap,
    output logic [NUM_CH*WIDTH-1:0] snap_data,
`endif
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    user_reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       up_dn,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    input  logic [NUM_CH*WIDTH-1:0] limit,
    output logic [NUM_CH*WIDTH-1:0] dataout,
    output logic [NUM_CH-1:0]       at_bound,
    output logic [NUM_CH-1:0]       tc
);

`ifdef CTR_SNAPSHOT_EN
    logic [NUM_CH*WIDTH-1:0] w_nxt;
    logic [NUM_CH*WIDTH-1:0] r_snap;
`endif

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam int unsigned LSB = ch_lsb(gi, WIDTH);
        ctr_ctrl_t w_ctrl;

        assign w_ctrl = '{en: en[gi], up_dn: up_dn[gi], load: load[gi]};

        ctr_channel #(
            .WIDTH     (WIDTH),
            .WRAP_MODE (WRAP_MODE)
        ) u_ch (
`ifdef CTR_SNAPSHOT_EN
            .o_nxt        (w_nxt[LSB +: WIDTH]),
`endif
            .clk          (clk),
            .areset       (areset),
            .i_user_reset (user_reset),
            .i_ctrl       (w_ctrl),
            .i_load_val   (load_val[LSB +: WIDTH]),
            .i_limit      (limit[LSB +: WIDTH]),
            .o_count      (dataout[LSB +: WIDTH]),
            .o_at_bound   (at_bound[gi]),
            .o_tc         (tc[gi])
        );
    end

`ifdef CTR_SNAPSHOT_EN
    // captures post-update values; user_reset leaves it alone
    always_ff @(posedge clk or negedge areset) begin
        if (!areset)
            r_snap <= '0;
        else if (snap)
            r_snap <= w_nxt;
    end

    assign snap_data = r_snap;
`endif

endmodule

// File: tb/tb_ctr_bank.sv
// Directed scoreboard bench for ctr_bank: saturate and wrap builds side by side.
module tb_ctr_bank;

    localparam int W = 4;
    localparam int N = 4;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic         clk = 1'b0;
    logic         areset;
    logic         user_reset;
    logic [N-1:0] en;
    logic [N-1:0] up_dn;
    logic [N-1:0] load;
    logic [N*W-1:0] load_val;
    logic [N*W-1:0] limit;
    logic [N*W-1:0] s_do, w_do;
    logic [N-1:0]   s_ab, w_ab, s_tc, w_tc;
`ifdef CTR_SNAPSHOT_EN
    logic           snap;
    logic [N*W-1:0] s_sd, w_sd;
`endif

    exp_t q[$];
    int   n_run  = 0;
    int   n_fail = 0;
    int   ts, tw;

    always #5 clk = ~clk;

    ctr_bank #(.WIDTH(W), .NUM_CH(N), .WRAP_MODE(0)) u_sat (
`ifdef CTR_SNAPSHOT_EN
        .snap       (snap),
        .snap_data  (s_sd),
`endif
        .clk        (clk),
        .areset     (areset),
        .user_reset (user_reset),
        .en         (en),
        .up_dn      (up_dn),
        .load       (load),
        .load_val   (load_val),
        .limit      (limit),
        .dataout    (s_do),
        .at_bound   (s_ab),
        .tc         (s_tc)
    );

    ctr_bank #(.WIDTH(W), .NUM_CH(N), .WRAP_MODE(1)) u_wrap (
`ifdef CTR_SNAPSHOT_EN
        .snap       (snap),
        .snap_data  (w_sd),
`endif
        .clk        (clk),
        .areset     (areset),
        .user_reset (user_reset),
        .en         (en),
        .up_dn      (up_dn),
        .load       (load),
        .load_val   (load_val),
        .limit      (limit),
        .dataout    (w_do),
        .at_bound   (w_ab),
        .tc         (w_tc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] sl(input logic [N*W-1:0] v, input int ch);
        return v[ch*W +: W];
    endfunction

    task automatic push(input string t, input logic [31:0] e);
        exp_t x;
        x.tag = t;
        x.exp = e;
        q.push_back(x);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t x;
        n_run++;
        if (q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0d expected none", obs);
        end else begin
            x = q.pop_front();
            assert (obs === x.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", x.tag, obs, x.exp);
            end
        end
    endtask

    initial begin
        areset = 1'b0; user_reset = 1'b0;
        en = '0; up_dn = '0; load = '0;
        load_val = '0; limit = '1;
`ifdef CTR_SNAPSHOT_EN
        snap = 1'b0;
`endif
        #2;
        push("rst_sat_do", 0);  check(32'(s_do));
        push("rst_wrap_do", 0); check(32'(w_do));
        push("rst_tc", 0);      check(32'({s_tc, w_tc}));
`ifdef CTR_SNAPSHOT_EN
        push("rst_snap", 0);    check(32'({s_sd, w_sd}));
`endif
        #1 areset = 1'b1;

        // T1: full-range up count, saturate vs wrap
        en = 4'b0001; up_dn = 4'b1111;
        push("t1_sat_3", 3); push("t1_wrap_3", 3);
        repeat (3) tick();
        check(32'(sl(s_do, 0))); check(32'(sl(w_do, 0)));
        ts = 0; tw = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            ts += int'(s_tc[0]);
            tw += int'(w_tc[0]);
        end
        push("t1_sat_15", 15);  check(32'(sl(s_do, 0)));
        push("t1_sat_tcs", 1);  check(32'(ts));
        push("t1_sat_ab", 1);   check(32'(s_ab[0]));
        push("t1_sat_tc_hold", 0); check(32'(s_tc[0]));
        push("t1_wrap_7", 7);   check(32'(sl(w_do, 0)));
        push("t1_wrap_tcs", 1); check(32'(tw));

        // T2: user_reset, then wrap at limit 9
        en = '0; user_reset = 1'b1;
        push("t2_ur_sat", 0); push("t2_ur_wrap", 0);
        tick();
        user_reset = 1'b0;
        check(32'(s_do)); check(32'(w_do));
        limit[0*W +: W] = 4'd9; en = 4'b0001;
        ts = 0; tw = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            ts += int'(s_tc[0]);
            tw += int'(w_tc[0]);
        end
        push("t2_wrap_2", 2);   check(32'(sl(w_do, 0)));
        push("t2_wrap_tcs", 1); check(32'(tw));
        push("t2_sat_9", 9);    check(32'(sl(s_do, 0)));
        push("t2_sat_tcs", 1);  check(32'(ts));

        // T3: load clamped to limit, then count down past zero
        en = '0; load = 4'b0001;
        load_val[0*W +: W] = 4'd12; limit[0*W +: W] = 4'd10;
        push("t3_ld_sat", 10); push("t3_ld_wrap", 10); push("t3_ld_tc", 0);
        tick();
        load = '0;
        check(32'(sl(s_do, 0))); check(32'(sl(w_do, 0)));
        check(32'({s_tc[0], w_tc[0]}));
        up_dn[0] = 1'b0; en = 4'b0001;
        ts = 0; tw = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            ts += int'(s_tc[0]);
            tw += int'(w_tc[0]);
        end
        push("t3_wrap_10", 10); check(32'(sl(w_do, 0)));
        push("t3_wrap_tc", 1);  check(32'(w_tc[0]));
        push("t3_wrap_tcs", 1); check(32'(tw));
        push("t3_sat_0", 0);    check(32'(sl(s_do, 0)));
        push("t3_sat_tcs", 1);  check(32'(ts));
        push("t3_sat_ab", 1);   check(32'(s_ab[0]));

        // T4: user_reset beats load/en; then load and en on separate channels
        up_dn = 4'b1111; en = 4'b0010; load = 4'b0001;
        load_val[0*W +: W] = 4'd5; user_reset = 1'b1;
        push("t4_ur_sat", 0); push("t4_ur_wrap", 0);
        tick();
        user_reset = 1'b0;
        check(32'(s_do)); check(32'(w_do));
        push("t4_sat_ch0", 5); push("t4_sat_ch1", 1); push("t4_wrap_ch1", 1);
        tick();
        load = '0;
        check(32'(sl(s_do, 0))); check(32'(sl(s_do, 1))); check(32'(sl(w_do, 1)));

        // limit 0 on ch3: saturate sits at 0, wrap pulses every cycle
        en = 4'b1000; limit[3*W +: W] = 4'd0;
        for (int i = 0; i < 2; i++) begin
            push("l0_sat", 0); push("l0_sat_tc", 0);
            push("l0_wrap", 0); push("l0_wrap_tc", 1);
            tick();
            check(32'(sl(s_do, 3))); check(32'(s_tc[3]));
            check(32'(sl(w_do, 3))); check(32'(w_tc[3]));
        end
        push("l0_sat_ab", 1); check(32'(s_ab[3]));

        // T5: async reset mid-count
        en = 4'b0100;
        push("t5_sat_6", 6);
        repeat (6) tick();
        check(32'(sl(s_do, 2)));
        #2 areset = 1'b0;
        push("t5_async_sat", 0); push("t5_async_wrap", 0);
        #1;
        check(32'(s_do)); check(32'(w_do));
        #1 areset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            push("t5_resume_sat", 32'(k)); push("t5_resume_wrap", 32'(k));
            tick();
            check(32'(sl(s_do, 2))); check(32'(sl(w_do, 2)));
        end

        // limit lowered below count
        limit[2*W +: W] = 4'd1;
        push("lo_sat", 1); push("lo_sat_tc", 0);
        push("lo_wrap", 0); push("lo_wrap_tc", 1);
        tick();
        check(32'(sl(s_do, 2))); check(32'(s_tc[2]));
        check(32'(sl(w_do, 2))); check(32'(w_tc[2]));

`ifdef CTR_SNAPSHOT_EN
        // T6: atomic snapshot of post-update values, held afterwards
        en = '0; limit = '1; load = 4'b1111;
        load_val = {4'd4, 4'd3, 4'd2, 4'd1};
        tick();
        load = '0; en = 4'b1111; snap = 1'b1;
        push("t6_snap_sat", 32'h5432); push("t6_snap_wrap", 32'h5432);
        tick();
        snap = 1'b0;
        check(32'(s_sd)); check(32'(w_sd));
        push("t6_hold_sat", 32'h5432);
        repeat (2) tick();
        check(32'(s_sd));
        user_reset = 1'b1;
        push("t6_ur_hold", 32'h5432); push("t6_ur_do", 0);
        tick();
        user_reset = 1'b0;
        check(32'(s_sd)); check(32'(s_do));
`endif

        if (q.size() != 0) begin
            n_run++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
